// File: rtl/alu_sel_pkg.sv
// rtl/alu_sel_pkg.sv - sel op codes shared with the button controller, executor states
package alu_sel_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_STOP  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } exec_state_t;

endpackage

// File: rtl/alu_sel_executor_if.sv
// rtl/alu_sel_executor_if.sv - sel/operand bus from the button FSM and result bus to the display
interface alu_sel_executor_if #(parameter int WIDTH = 8);
  logic [2:0]         sel;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;
  logic               neg;
  logic               err;

  modport master (output sel, start, a, b, input result, busy, done, neg, err);
  modport slave  (input sel, start, a, b, output result, busy, done, neg, err);
endinterface

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - iterative unsigned multiplier / restoring divider, one bit per cycle
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_or_qr,
  output logic               fin
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic               div_r;
  logic [WIDTH-1:0]   op_r;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rs;
  logic [WIDTH:0]     diff;

  // p holds {acc, multiplier} for MUL and {remainder, quotient/dividend} for DIV
  always_comb begin
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, op_r} : '0);
    rs      = p[2*WIDTH-1:WIDTH-1];
    diff    = rs - {1'b0, op_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      div_r <= 1'b0;
      op_r  <= '0;
      p     <= '0;
      fin   <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (go) begin
        p     <= is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
        op_r  <= is_div ? b : a;
        div_r <= is_div;
        cnt   <= CW'(WIDTH);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) fin <= 1'b1;
        if (div_r) begin
          if (!diff[WIDTH]) p <= {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
          else              p <= {rs[WIDTH-1:0],   p[WIDTH-2:0], 1'b0};
        end else begin
          p <= {mul_sum, p[WIDTH-1:1]};
        end
      end
    end
  end

  assign prod_or_qr = p;

endmodule

// File: rtl/alu_sel_executor.sv
// rtl/alu_sel_executor.sv - launches ops on sel change or start, holds result for display
module alu_sel_executor
  import alu_sel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  alu_sel_executor_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  exec_state_t        state;
  logic [2:0]         sel_q;
  logic [2:0]         sel_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] res_s;
  logic               neg_s;
  logic               err_s;
  logic [2*WIDTH-1:0] simple_res;
  logic               simple_neg;
  logic               simple_err;
  logic [SHW-1:0]     sh;
  logic               launch;
  logic               go;
  logic               fin;
  logic [2*WIDTH-1:0] md_q;

  assign launch = (state == ST_IDLE || state == ST_DONE) && (bus.sel != sel_q || bus.start);
  // divide by zero bypasses the iterative path and is answered in EXEC
  assign go = launch && (bus.sel == OP_MUL || (bus.sel == OP_DIV && bus.b != '0));
  assign sh = b_r[SHW-1:0];

  always_comb begin
    simple_res = '0;
    simple_neg = 1'b0;
    simple_err = 1'b0;
    case (sel_r)
      OP_ADD:   simple_res = {{(WIDTH-1){1'b0}}, {1'b0, a_r} + {1'b0, b_r}};
      OP_SUB: begin
        simple_res = {{WIDTH{1'b0}}, a_r - b_r};
        simple_neg = a_r < b_r;
      end
      OP_LEFT:  simple_res = {{WIDTH{1'b0}}, a_r} << sh;
      OP_RIGHT: simple_res = {{WIDTH{1'b0}}, a_r >> sh};
      OP_DIV: begin
        simple_res = {a_r, {WIDTH{1'b1}}};
        simple_err = 1'b1;
      end
      default:  simple_res = '0;
    endcase
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .is_div     (bus.sel == OP_DIV),
    .a          (bus.a),
    .b          (bus.b),
    .prod_or_qr (md_q),
    .fin        (fin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel_q      <= OP_NOP;
      sel_r      <= OP_NOP;
      a_r        <= '0;
      b_r        <= '0;
      res_s      <= '0;
      neg_s      <= 1'b0;
      err_s      <= 1'b0;
      bus.result <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.neg    <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_EXEC: begin
          res_s <= simple_res;
          neg_s <= simple_neg;
          err_s <= simple_err;
          state <= ST_DONE;
        end
        ST_ITER: if (fin) begin
          res_s <= md_q;
          neg_s <= 1'b0;
          err_s <= 1'b0;
          state <= ST_DONE;
        end
        ST_DONE: begin
          bus.result <= res_s;
          bus.neg    <= neg_s;
          bus.err    <= err_s;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // a launch out of DONE overrides the return to IDLE and keeps busy high
      if (launch) begin
        sel_q    <= bus.sel;
        sel_r    <= bus.sel;
        a_r      <= bus.a;
        b_r      <= bus.b;
        bus.busy <= 1'b1;
        state    <= go ? ST_ITER : ST_EXEC;
      end
    end
  end

endmodule

// File: tb/tb_alu_sel_executor.sv
// tb/tb_alu_sel_executor.sv - random and directed ops against an arithmetic reference model
module tb_alu_sel_executor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sel_executor_if #(.WIDTH(W)) bus();
  alu_sel_executor #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  logic [2:0] last_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {err, neg, result[15:0]}
  function automatic logic [17:0] model(input logic [2:0] s, input logic [7:0] av, input logic [7:0] bv);
    int unsigned x, y, sh;
    logic [15:0] r;
    logic n, e;
    x = av; y = bv; sh = bv % W;
    r = 16'h0; n = 1'b0; e = 1'b0;
    case (s)
      3'd1: r = 16'(x + y);
      3'd2: begin r = 16'((x + 256 - y) % 256); n = (x < y); end
      3'd3: r = 16'(x * (1 << sh));
      3'd4: r = 16'(x / (1 << sh));
      3'd5: r = 16'(x * y);
      3'd6: if (y == 0) begin r = 16'(x * 256 + 255); e = 1'b1; end
            else r = 16'((x % y) * 256 + x / y);
      default: r = 16'h0;
    endcase
    return {e, n, r};
  endfunction

  function automatic int latency(input logic [2:0] s, input logic [7:0] bv);
    return (s == 3'd5 || (s == 3'd6 && bv != 0)) ? W + 2 : 2;
  endfunction

  task automatic run_op(input logic [2:0] s, input logic [7:0] av, input logic [7:0] bv,
                        input bit st, input string tag);
    logic [17:0] m;
    logic [15:0] prev;
    int edges, busy_n;
    bit stable;
    m = model(s, av, bv);
    prev = bus.result;
    bus.sel = s; bus.a = av; bus.b = bv; bus.start = st;
    tick;
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    edges = 0; busy_n = 0; stable = 1'b1;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_n++;
      if (bus.result !== prev) stable = 1'b0;
      tick;
      edges++;
    end
    chk({tag, ".latency"}, edges, latency(s, bv));
    chk({tag, ".busy_cycles"}, busy_n, latency(s, bv));
    chk({tag, ".result"}, bus.result, m[15:0]);
    chk({tag, ".neg"}, bus.neg, m[16]);
    chk({tag, ".err"}, bus.err, m[17]);
    chk({tag, ".busy_at_done"}, bus.busy, 0);
    chk({tag, ".held"}, stable, 1);
    last_sel = s;
  endtask

  initial begin
    int edges;
    logic [2:0] s;
    logic [7:0] av, bv;
    bus.sel = 3'd0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    chk("reset.result", bus.result, 0);
    chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0);
    chk("reset.neg", bus.neg, 0);
    chk("reset.err", bus.err, 0);
    tick;
    chk("reset.no_launch_busy", bus.busy, 0);

    run_op(3'd1, 8'd200, 8'd100, 1'b0, "add");
    run_op(3'd2, 8'd5, 8'd9, 1'b0, "sub");
    run_op(3'd2, 8'd5, 8'd9, 1'b1, "sub_start");
    run_op(3'd5, 8'd15, 8'd17, 1'b0, "mul");
    run_op(3'd6, 8'd100, 8'd7, 1'b0, "div");
    run_op(3'd6, 8'd10, 8'd0, 1'b1, "div0");

    // MUL in flight, sel moves to LEFT mid-iteration
    bus.sel = 3'd5; bus.a = 8'h81; bus.b = 8'h01;
    tick; tick; tick;
    bus.sel = 3'd3;
    edges = 2;
    while (!bus.done && edges < 40) begin tick; edges++; end
    chk("mul_then_left.mul_latency", edges, W + 2);
    chk("mul_then_left.mul_result", bus.result, 16'h0081);
    tick;
    edges = 0;
    while (!bus.done && edges < 40) begin tick; edges++; end
    chk("mul_then_left.left_result", bus.result, 16'h0102);
    chk("mul_then_left.left_err", bus.err, 0);

    // reset in the middle of a DIV
    bus.sel = 3'd6; bus.a = 8'd100; bus.b = 8'd7;
    tick; tick; tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midreset.result", bus.result, 0);
    chk("midreset.busy", bus.busy, 0);
    chk("midreset.done", bus.done, 0);
    chk("midreset.neg", bus.neg, 0);
    chk("midreset.err", bus.err, 0);
    run_op(3'd6, 8'd100, 8'd7, 1'b0, "relaunch");

    for (int i = 0; i < 60; i++) begin
      s  = 3'($urandom_range(0, 7));
      av = 8'($urandom);
      bv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(s, av, bv, s == last_sel, "rand");
      for (int k = $urandom_range(0, 2); k > 0; k--) tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
